// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM state encoding and
// default wait-timeout sizing.
package mem_stage_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_TIMEOUT = 255;
    localparam int unsigned DEFAULT_CNT_W   = 10;

endpackage

// File: rtl/memory_access_cycle_if.sv
// Data-memory req/ready bus between the MEM stage (master) and the
// variable-latency data memory (slave).
interface memory_access_cycle_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ready,
        output dmem_rdata
    );

endinterface

// File: rtl/dmem_access_fsm.sv
// Handshake sequencer for one data-memory access: tracks IDLE/WAIT, counts
// wait cycles, and produces request, stall, capture and abort/kill strobes.
module dmem_access_fsm
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic access,
    input  logic misaligned,
    input  logic ready,
    output logic req,
    output logic stall,
    output logic capture,
    output logic kill
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t           state;
    state_t           stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // While reset is low every strobe stays at its default of 0.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        req       = 1'b0;
        stall     = 1'b0;
        capture   = 1'b0;
        kill      = 1'b0;
        if (reset) begin
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        if (misaligned) begin
                            kill = 1'b1;
                        end else begin
                            req = 1'b1;
                            if (ready) begin
                                capture = 1'b1;
                            end else begin
                                stall     = 1'b1;
                                stateNext = ST_WAIT;
                                cntNext   = CNT_W'(1);
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    req = access & ~misaligned;
                    if (ready) begin
                        capture   = 1'b1;
                        stateNext = ST_IDLE;
                        cntNext   = '0;
                    end else if (cnt < CNT_MAX) begin
                        stall   = 1'b1;
                        cntNext = cnt + 1'b1;
                    end else begin
                        // Timeout: drop the request and retire the instruction as a no-op.
                        req       = 1'b0;
                        kill      = 1'b1;
                        stateNext = ST_IDLE;
                        cntNext   = '0;
                    end
                end
                default: begin
                    stateNext = ST_IDLE;
                    cntNext   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/memory_access_cycle.sv
// MEM stage of the RV32 pipeline: drives the data-memory handshake, stalls the
// front of the pipe while waiting, and owns the MEM/WB register.
module memory_access_cycle
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         RegWriteM,
    input  logic                         MemWriteM,
    input  logic                         ResultSrcM,
    input  logic [4:0]                   RD_M,
    input  logic [31:0]                  PCPlus4M,
    input  logic [31:0]                  WriteDataM,
    input  logic [31:0]                  ALU_ResultM,
    memory_access_cycle_if.master        dmem,
    output logic                         StallM,
    output logic                         RegWriteW,
    output logic                         ResultSrcW,
    output logic [4:0]                   RD_W,
    output logic [31:0]                  PCPlus4W,
    output logic [31:0]                  ALU_ResultW,
    output logic [31:0]                  ReadDataW,
    output logic                         MemErr
);

    logic access;
    logic misaligned;
    logic req;
    logic capture;
    logic kill;

    assign access     = MemWriteM | ResultSrcM;
    assign misaligned = (ALU_ResultM[1:0] != 2'b00);

    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = MemWriteM;
    assign dmem.dmem_addr  = ALU_ResultM;
    assign dmem.dmem_wdata = WriteDataM;

    dmem_access_fsm #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .access     (access),
        .misaligned (misaligned),
        .ready      (dmem.dmem_ready),
        .req        (req),
        .stall      (StallM),
        .capture    (capture),
        .kill       (kill)
    );

    // A stalled edge leaves a bubble: only RegWriteW drops, the rest holds.
    always_ff @(posedge clk) begin
        if (!reset) begin
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 1'b0;
            RD_W        <= '0;
            PCPlus4W    <= '0;
            ALU_ResultW <= '0;
            ReadDataW   <= '0;
            MemErr      <= 1'b0;
        end else if (StallM) begin
            RegWriteW <= 1'b0;
        end else begin
            RegWriteW   <= RegWriteM & ~kill;
            ResultSrcW  <= ResultSrcM;
            RD_W        <= RD_M;
            PCPlus4W    <= PCPlus4M;
            ALU_ResultW <= ALU_ResultM;
            ReadDataW   <= capture ? dmem.dmem_rdata : '0;
            MemErr      <= MemErr | kill;
        end
    end

endmodule

// File: tb/tb_memory_access_cycle.sv
// Randomized self-checking bench for memory_access_cycle against a
// transaction-level model of the MEM stage.
module tb_memory_access_cycle;

    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
    logic        StallM, RegWriteW, ResultSrcW, MemErr;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

    memory_access_cycle_if dbus ();

    memory_access_cycle #(
        .TIMEOUT (T),
        .CNT_W   (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .RD_M        (RD_M),
        .PCPlus4M    (PCPlus4M),
        .WriteDataM  (WriteDataM),
        .ALU_ResultM (ALU_ResultM),
        .dmem        (dbus.master),
        .StallM      (StallM),
        .RegWriteW   (RegWriteW),
        .ResultSrcW  (ResultSrcW),
        .RD_W        (RD_W),
        .PCPlus4W    (PCPlus4W),
        .ALU_ResultW (ALU_ResultW),
        .ReadDataW   (ReadDataW),
        .MemErr      (MemErr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: what MEM/WB and the error flag must hold after each edge.
    logic        mRW, mRS, mErr;
    logic [4:0]  mRD;
    logic [31:0] mPC, mALU, mRData;
    logic        expReq, expStall;
    logic        chkOn = 1'b0;
    int          stallSeen, reqSeen;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic modelClear();
        mRW = 1'b0; mRS = 1'b0; mRD = '0; mPC = '0; mALU = '0; mRData = '0; mErr = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chkOn) begin
            chk("dmem_req",    32'(dbus.dmem_req), 32'(expReq));
            chk("StallM",      32'(StallM),        32'(expStall));
            chk("dmem_addr",   dbus.dmem_addr,     ALU_ResultM);
            chk("dmem_we",     32'(dbus.dmem_we),  32'(MemWriteM));
            chk("dmem_wdata",  dbus.dmem_wdata,    WriteDataM);
            chk("RegWriteW",   32'(RegWriteW),     32'(mRW));
            chk("ResultSrcW",  32'(ResultSrcW),    32'(mRS));
            chk("RD_W",        32'(RD_W),          32'(mRD));
            chk("PCPlus4W",    PCPlus4W,           mPC);
            chk("ALU_ResultW", ALU_ResultW,        mALU);
            chk("ReadDataW",   ReadDataW,          mRData);
            chk("MemErr",      32'(MemErr),        32'(mErr));
        end
    end

    // One instruction through MEM. L = ready-low cycles the memory inserts
    // before asserting ready; L > T means the memory never answers in time.
    task automatic doInstr(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                           input logic [31:0] pc, input logic [31:0] wd, input logic [31:0] addr,
                           input int unsigned L, input logic [31:0] rdv);
        logic        go, aborted;
        int unsigned nCyc, mn;
        go      = (mw | rs) && (addr[1:0] == 2'b00);
        aborted = go && (L > T);
        mn      = (L < T) ? L : T;
        nCyc    = go ? mn + 1 : 1;
        stallSeen = 0;
        reqSeen   = 0;
        for (int unsigned k = 0; k < nCyc; k++) begin
            RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RD_M = rd;
            PCPlus4M = pc; WriteDataM = wd; ALU_ResultM = addr;
            dbus.dmem_ready = go ? (k == L) : 1'($urandom);
            dbus.dmem_rdata = (go && k == L) ? rdv : $urandom;
            expReq   = go && !(aborted && k == T);
            expStall = go && (k < mn);
            @(negedge clk);
            stallSeen += int'(StallM);
            reqSeen   += int'(dbus.dmem_req);
            @(posedge clk);
            #1;
            if (k + 1 < nCyc) begin
                mRW = 1'b0;
            end else begin
                mRW    = rw && !aborted && !((mw | rs) && addr[1:0] != 2'b00);
                mRS    = rs;
                mRD    = rd;
                mPC    = pc;
                mALU   = addr;
                mRData = (go && !aborted) ? rdv : 32'h0;
                mErr   = mErr | ((mw | rs) && !go) | aborted;
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; RD_M = '0;
        PCPlus4M = '0; WriteDataM = '0; ALU_ResultM = '0;
        dbus.dmem_ready = 1'b0; dbus.dmem_rdata = '0;
        expReq = 1'b0; expStall = 1'b0;
        modelClear();
        repeat (2) @(posedge clk);
        #1;
        chkOn = 1'b1;
        @(negedge clk);
        chk("reset_RegWriteW", 32'(RegWriteW), 32'h0);
        chk("reset_MemErr",    32'(MemErr),    32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Zero-wait load.
        doInstr(1, 0, 1, 5'd5, 32'h44, 32'h0, 32'h100, 0, 32'hDEADBEEF);
        chk("load0_stalls",   32'(stallSeen), 32'd0);
        chk("load0_RegWrite", 32'(RegWriteW), 32'h1);
        chk("load0_RD_W",     32'(RD_W),      32'd5);
        chk("load0_data",     ReadDataW,      32'hDEADBEEF);

        // Store with ready on the 4th cycle.
        doInstr(0, 1, 0, 5'd0, 32'h48, 32'h1234, 32'h20, 3, 32'h0);
        chk("store_stalls",   32'(stallSeen), 32'd3);
        chk("store_reqs",     32'(reqSeen),   32'd4);
        chk("store_RegWrite", 32'(RegWriteW), 32'h0);

        // 2-wait load immediately followed by an ALU op.
        doInstr(1, 0, 1, 5'd3, 32'h4C, 32'h0, 32'h40, 2, 32'hCAFEF00D);
        chk("load2_stalls", 32'(stallSeen), 32'd2);
        chk("load2_data",   ReadDataW,      32'hCAFEF00D);
        chk("load2_RD_W",   32'(RD_W),      32'd3);
        doInstr(1, 0, 0, 5'd7, 32'h50, 32'h0, 32'h77, 0, 32'h0);
        chk("alu_RD_W",     32'(RD_W),      32'd7);
        chk("alu_RegWrite", 32'(RegWriteW), 32'h1);
        chk("alu_MemErr",   32'(MemErr),    32'h0);

        // Misaligned load.
        doInstr(1, 0, 1, 5'd9, 32'h54, 32'h0, 32'h102, 0, 32'h11111111);
        chk("mis_reqs",     32'(reqSeen),   32'd0);
        chk("mis_stalls",   32'(stallSeen), 32'd0);
        chk("mis_RegWrite", 32'(RegWriteW), 32'h0);
        chk("mis_MemErr",   32'(MemErr),    32'h1);

        // Timeout with the memory never answering.
        doInstr(1, 0, 1, 5'd10, 32'h58, 32'h0, 32'h200, 50, 32'h0);
        chk("to_stalls",   32'(stallSeen), 32'd4);
        chk("to_reqs",     32'(reqSeen),   32'd4);
        chk("to_RegWrite", 32'(RegWriteW), 32'h0);
        doInstr(1, 0, 1, 5'd11, 32'h5C, 32'h0, 32'h300, 1, 32'h2222);
        chk("to_sticky",   32'(MemErr),    32'h1);

        // Randomized instruction mix.
        for (int i = 0; i < 300; i++) begin
            int unsigned typ;
            logic [31:0] a;
            typ = $urandom % 5;
            a = $urandom;
            if ($urandom % 8 != 0) a[1:0] = 2'b00;
            doInstr(1'($urandom), typ == 4, typ == 2 || typ == 3, 5'($urandom), $urandom,
                    $urandom, a, $urandom % 7, $urandom);
        end

        // Reset asserted in WAIT cycle 2 of a load.
        RegWriteM = 1; MemWriteM = 0; ResultSrcM = 1; RD_M = 5'd12;
        PCPlus4M = 32'h60; WriteDataM = '0; ALU_ResultM = 32'h80;
        dbus.dmem_ready = 1'b0;
        expReq = 1'b1; expStall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            mRW = 1'b0;
        end
        reset = 1'b0;
        expReq = 1'b0; expStall = 1'b0;
        @(negedge clk);
        chk("rst_req",   32'(dbus.dmem_req), 32'h0);
        chk("rst_stall", 32'(StallM),        32'h0);
        @(posedge clk);
        #1;
        modelClear();
        chk("rst_MemErr",   32'(MemErr),    32'h0);
        chk("rst_PCPlus4W", PCPlus4W,       32'h0);
        chk("rst_RD_W",     32'(RD_W),      32'h0);
        chk("rst_ReadData", ReadDataW,      32'h0);
        reset = 1'b1;
        doInstr(1, 0, 1, 5'd13, 32'h64, 32'h0, 32'h84, 1, 32'h5A5A5A5A);
        chk("post_rst_data", ReadDataW, 32'h5A5A5A5A);

        chkOn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_access_cycle.md
Name: memory_access_cycle

Overview:
- MEM stage of the 5-stage RV32 pipeline; consumes the EX/MEM register outputs (RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM).
- Runs a req/ready handshake to a variable-latency data memory.
- Drives StallM to the hazard unit and owns the MEM/WB pipeline register feeding writeback and forwarding (ResultW path).

Parameters:
- TIMEOUT, 255: maximum WAIT cycles before an access is aborted (range 1..1023).
- CNT_W, 10: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- RegWriteM  in  1  register write enable.
- MemWriteM  in  1  store.
- ResultSrcM  in  1  load (1) vs ALU result (0).
- RD_M  in  5  destination register.
- PCPlus4M  in  32  PC+4.
- WriteDataM  in  32  store data.
- ALU_ResultM  in  32  effective address / ALU result.
- dmem_ready  in  1  memory accepts/completes the current request.
- dmem_rdata  in  32  load data; valid in the cycle dmem_ready=1.
- dmem_req  out  1  access request.
- dmem_we  out  1  write strobe.
- dmem_addr  out  32  word address.
- dmem_wdata  out  32  store data.
- StallM  out  1  freeze PC/IF-ID/ID-EX/EX-MEM registers.
- RegWriteW  out  1  MEM/WB register write enable.
- ResultSrcW  out  1  MEM/WB load select.
- RD_W  out  5  MEM/WB destination register.
- PCPlus4W  out  32  MEM/WB PC+4.
- ALU_ResultW  out  32  MEM/WB ALU result.
- ReadDataW  out  32  MEM/WB load data.
- MemErr  out  1  sticky access-error flag.

Behaviour:
- Access = MemWriteM | ResultSrcM. Misaligned = ALU_ResultM[1:0] != 0.
- Reset (reset=0 at an edge): state IDLE, counter 0, MemErr 0, all W outputs 0. While reset=0, dmem_req=0 and StallM=0 combinationally. Reset during WAIT abandons the access; the memory must tolerate a dropped req.
- dmem_addr=ALU_ResultM, dmem_wdata=WriteDataM, dmem_we=MemWriteM: driven combinationally at all times.
- dmem_req = Access & ~Misaligned & (state IDLE or WAIT).
- Once dmem_req=1, req/addr/we/wdata stay stable until dmem_ready=1. EX/MEM is frozen by StallM, so this holds by construction.
- IDLE, non-access: StallM=0; MEM/WB loads the M inputs; ReadDataW<=0.
- IDLE, aligned access with dmem_ready=1 (zero-wait memory): StallM=0; MEM/WB loads; ReadDataW<=dmem_rdata. Latency 1 cycle, identical to a single-cycle memory.
- IDLE, aligned access with dmem_ready=0: StallM=1; go to WAIT; counter<=1.
- WAIT, dmem_ready=1: StallM=0; MEM/WB loads, ReadDataW<=dmem_rdata; go to IDLE; counter<=0.
- WAIT, dmem_ready=0, counter<TIMEOUT: StallM=1; counter++.
- WAIT, dmem_ready=0, counter==TIMEOUT: abort; dmem_req=0 in this cycle; StallM=0; MEM/WB loads with RegWriteW forced 0; MemErr<=1; go to IDLE.
- Misaligned access in IDLE: no request issued; StallM=0; MEM/WB loads with RegWriteW forced 0; MemErr<=1.
- Every edge with StallM=1 inserts a bubble: RegWriteW<=0; other W fields hold. This prevents a duplicate writeback and stale forwarding.
- A store completes with RegWriteW=RegWriteM (normally 0).
- Back-to-back accesses: the next access is presented in IDLE the cycle after completion, with no idle cycle required.
- MemErr clears only on reset.
- Word accesses only: no byte or halfword support, no funct3 input.

Decomposition:
- Package mem_stage_pkg: state encoding (ST_IDLE=0, ST_WAIT=1) and the default TIMEOUT constant.
- Sub-module dmem_access_fsm: state register, wait counter, dmem_req/StallM/abort generation.
- Top level: holds the MEM/WB register and the bubble/force-zero logic.

Test Plan:
- Load, RD_M=5, ALU_ResultM=0x100, dmem_ready tied 1, rdata=0xDEADBEEF -> no StallM; next edge RegWriteW=1, RD_W=5, ReadDataW=0xDEADBEEF.
- Store addr 0x20, data 0x1234, ready asserted after 3 cycles -> dmem_req/we high 4 cycles with stable addr/data; StallM=1 for 3 cycles; RegWriteW=0 throughout; completes the 4th cycle.
- Load with 2-cycle wait immediately followed by an ALU op RD_M=7 -> load writes back after the stall; ALU op reaches RD_W=7 on the very next edge.
- Load to 0x102 (misaligned) -> dmem_req never asserted; MemErr=1; RegWriteW=0; no stall.
- TIMEOUT=4, dmem_ready held 0 -> StallM=1 for 4 cycles; abort on the 5th with RegWriteW=0; MemErr stays 1 over later clean accesses.
- reset=0 asserted in WAIT cycle 2 -> next edge: state IDLE, all W outputs 0, MemErr 0; dmem_req=0 and StallM=0 while reset is low.
